// File: rtl/uram_port_arbiter.sv
// Shares one simple-dual-port URAM bank between NUM_REQ requesters: independent
// round-robin read/write arbitration, tagged read-response routing, and a zero-fill sequencer.

module uram_rr_arb #(
   parameter int NUM_REQ = 4,
   parameter int PW      = $clog2(NUM_REQ)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               enable,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [PW-1:0]      grant_idx
);
   logic [PW-1:0] ptr;
   logic [PW:0]   pos;
   logic          found;

   // Walk the requesters starting at ptr, wrapping once; first hit wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      pos       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = {1'b0, ptr} + (PW+1)'(k);
         if (pos >= (PW+1)'(NUM_REQ)) pos = pos - (PW+1)'(NUM_REQ);
         if (enable && !found && req[pos[PW-1:0]]) begin
            found                 = 1'b1;
            grant[pos[PW-1:0]]    = 1'b1;
            grant_idx             = pos[PW-1:0];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)   ptr <= '0;
      else if (found) ptr <= (grant_idx == PW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
   end
endmodule

module uram_port_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 14,
   parameter int READ_LATENCY  = 2
) (
   input  logic                                     clock,
   input  logic                                     reset_n,
   input  logic [NUM_REQ-1:0]                       rd_req_valid,
   output logic [NUM_REQ-1:0]                       rd_req_ready,
   input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]    rd_req_addr,
   output logic [NUM_REQ-1:0]                       rd_resp_valid,
   output logic [DATA_WIDTH-1:0]                    rd_resp_data,
   input  logic [NUM_REQ-1:0]                       wr_req_valid,
   output logic [NUM_REQ-1:0]                       wr_req_ready,
   input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]    wr_req_addr,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]       wr_req_data,
   input  logic                                     clear_start,
   output logic                                     busy,
   output logic [ADDRESS_WIDTH-1:0]                 mem_raddr,
   input  logic [DATA_WIDTH-1:0]                    mem_dout,
   output logic                                     mem_wen,
   output logic [ADDRESS_WIDTH-1:0]                 mem_waddr,
   output logic [DATA_WIDTH-1:0]                    mem_din
);
   localparam int PW = $clog2(NUM_REQ);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                                 state;
   logic                                   run;
   logic [ADDRESS_WIDTH-1:0]               clr_cnt;
   logic [ADDRESS_WIDTH-1:0]               raddr_q;
   logic [NUM_REQ-1:0]                     rd_gnt, wr_gnt;
   logic [PW-1:0]                          rd_idx, wr_idx;
   logic [READ_LATENCY-1:0][NUM_REQ-1:0]   tag_pipe;

   assign run = (state == RUN);

   uram_rr_arb #(.NUM_REQ(NUM_REQ)) u_rd_arb (
      .clock(clock), .reset_n(reset_n), .enable(run),
      .req(rd_req_valid), .grant(rd_gnt), .grant_idx(rd_idx)
   );

   uram_rr_arb #(.NUM_REQ(NUM_REQ)) u_wr_arb (
      .clock(clock), .reset_n(reset_n), .enable(run),
      .req(wr_req_valid), .grant(wr_gnt), .grant_idx(wr_idx)
   );

   assign rd_req_ready  = rd_gnt;
   assign wr_req_ready  = wr_gnt;
   assign busy          = !run;
   assign mem_raddr     = (|rd_gnt) ? rd_req_addr[rd_idx] : raddr_q;
   assign rd_resp_valid = tag_pipe[READ_LATENCY-1];
   assign rd_resp_data  = mem_dout;

   // While clearing, the write port belongs to the zero-fill sequencer.
   always_comb begin
      mem_wen   = 1'b1;
      mem_waddr = clr_cnt;
      mem_din   = '0;
      if (run) begin
         mem_wen   = |wr_gnt;
         mem_waddr = wr_req_addr[wr_idx];
         mem_din   = wr_req_data[wr_idx];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else if (state == CLEAR) begin
         clr_cnt <= clr_cnt + 1'b1;
         if (&clr_cnt) state <= RUN;
      end else if (clear_start) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end
   end

   // One-hot tags track which requester owns the data emerging from the bank.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tag_pipe <= '0;
         raddr_q  <= '0;
      end else begin
         tag_pipe[0] <= rd_gnt;
         for (int s = 1; s < READ_LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
         raddr_q <= mem_raddr;
      end
   end
endmodule

// File: tb/tb_uram_port_arbiter.sv
// Randomized and directed bench for uram_port_arbiter against a transaction-level
// model of the arbitration rules, the bank contents and the response timing.

module tb_uram_port_arbiter;
   localparam int NR = 4, DW = 16, AW = 4, RL = 2, DEPTH = 16;

   logic                   clock = 1'b0;
   logic                   reset_n = 1'b1;
   logic [NR-1:0]          rd_req_valid = '0, rd_req_ready, rd_resp_valid;
   logic [NR-1:0][AW-1:0]  rd_req_addr = '0;
   logic [DW-1:0]          rd_resp_data;
   logic [NR-1:0]          wr_req_valid = '0, wr_req_ready;
   logic [NR-1:0][AW-1:0]  wr_req_addr = '0;
   logic [NR-1:0][DW-1:0]  wr_req_data = '0;
   logic                   clear_start = 1'b0, busy;
   logic [AW-1:0]          mem_raddr, mem_waddr;
   logic [DW-1:0]          mem_dout = '0, mem_din;
   logic                   mem_wen;

   uram_port_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(RL)) dut (
      .clock(clock), .reset_n(reset_n),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
      .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
      .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
      .wr_req_data(wr_req_data), .clear_start(clear_start), .busy(busy),
      .mem_raddr(mem_raddr), .mem_dout(mem_dout), .mem_wen(mem_wen),
      .mem_waddr(mem_waddr), .mem_din(mem_din)
   );

   always #5 clock = ~clock;

   // URAM wrapper stand-in: read-first, two-cycle read latency.
   logic [DW-1:0] umem [DEPTH];
   logic [DW-1:0] rd_s1;
   logic          fill = 1'b0;
   always @(posedge clock) begin
      rd_s1    <= umem[mem_raddr];
      mem_dout <= rd_s1;
      if (fill) for (int i = 0; i < DEPTH; i++) umem[i] <= 16'hFFFF;
      else if (mem_wen) umem[mem_waddr] <= mem_din;
   end

   // Reference model state
   bit            m_run;
   int            m_cnt, m_rptr, m_wptr, cyc;
   logic [DW-1:0] m_mem [DEPTH];
   logic [NR-1:0] exp_v [8];
   logic [DW-1:0] exp_d [8];
   logic [NR-1:0] rd_pend = '0, wr_pend = '0;
   logic [AW-1:0] rd_a [NR], wr_a [NR];
   logic [DW-1:0] wr_d [NR];
   logic [NR-1:0] obs_rg, obs_wg;
   logic          obs_busy;
   int            vecs = 0, errs = 0;

   task automatic model_reset();
      m_run = 0; m_cnt = 0; m_rptr = 0; m_wptr = 0;
      for (int i = 0; i < 8; i++) exp_v[i] = '0;
   endtask

   // One clock of stimulus, checked against the model's prediction.
   task automatic step(input bit clr);
      logic [NR-1:0] eg_r, eg_w;
      int ri, wi, idx, slot;
      for (int i = 0; i < NR; i++) begin
         rd_req_valid[i] = rd_pend[i]; rd_req_addr[i] = rd_a[i];
         wr_req_valid[i] = wr_pend[i]; wr_req_addr[i] = wr_a[i]; wr_req_data[i] = wr_d[i];
      end
      clear_start = clr;
      @(negedge clock);
      obs_rg = rd_req_ready; obs_wg = wr_req_ready; obs_busy = busy;
      eg_r = '0; eg_w = '0; ri = -1; wi = -1;
      if (m_run) begin
         for (int k = 0; k < NR; k++) begin
            idx = (m_rptr + k) % NR;
            if (ri < 0 && rd_pend[idx]) begin ri = idx; eg_r[idx] = 1'b1; end
            idx = (m_wptr + k) % NR;
            if (wi < 0 && wr_pend[idx]) begin wi = idx; eg_w[idx] = 1'b1; end
         end
      end
      vecs++; if (rd_req_ready !== eg_r) begin errs++; $display("FAIL rd_ready cyc=%0d got %b want %b", cyc, rd_req_ready, eg_r); end
      vecs++; if (wr_req_ready !== eg_w) begin errs++; $display("FAIL wr_ready cyc=%0d got %b want %b", cyc, wr_req_ready, eg_w); end
      vecs++; if (busy !== !m_run) begin errs++; $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, !m_run); end
      vecs++; if (mem_wen !== (!m_run || wi >= 0)) begin errs++; $display("FAIL mem_wen cyc=%0d got %b want %b", cyc, mem_wen, (!m_run || wi >= 0)); end
      if (!m_run) begin
         vecs++; if (mem_waddr !== AW'(m_cnt) || mem_din !== '0) begin errs++; $display("FAIL clear_write cyc=%0d got a=%0d d=%h want a=%0d d=0", cyc, mem_waddr, mem_din, m_cnt); end
      end else if (wi >= 0) begin
         vecs++; if (mem_waddr !== wr_a[wi] || mem_din !== wr_d[wi]) begin errs++; $display("FAIL wr_route cyc=%0d got a=%0d d=%h want a=%0d d=%h", cyc, mem_waddr, mem_din, wr_a[wi], wr_d[wi]); end
      end
      if (ri >= 0) begin
         vecs++; if (mem_raddr !== rd_a[ri]) begin errs++; $display("FAIL rd_route cyc=%0d got %0d want %0d", cyc, mem_raddr, rd_a[ri]); end
      end
      slot = cyc % 8;
      vecs++; if (rd_resp_valid !== exp_v[slot]) begin errs++; $display("FAIL resp_valid cyc=%0d got %b want %b", cyc, rd_resp_valid, exp_v[slot]); end
      if (exp_v[slot] != '0) begin
         vecs++; if (rd_resp_data !== exp_d[slot]) begin errs++; $display("FAIL resp_data cyc=%0d got %h want %h", cyc, rd_resp_data, exp_d[slot]); end
      end
      exp_v[slot] = '0;
      if (ri >= 0) begin
         exp_v[(cyc+RL)%8] = eg_r; exp_d[(cyc+RL)%8] = m_mem[rd_a[ri]];
         rd_pend[ri] = 1'b0; m_rptr = (ri + 1) % NR;
      end
      if (!m_run) begin
         m_mem[m_cnt] = '0;
         if (m_cnt == DEPTH-1) m_run = 1;
         m_cnt = (m_cnt + 1) % DEPTH;
      end else begin
         if (wi >= 0) begin
            m_mem[wr_a[wi]] = wr_d[wi]; wr_pend[wi] = 1'b0; m_wptr = (wi + 1) % NR;
         end
         if (clr) begin m_run = 0; m_cnt = 0; end
      end
      @(posedge clock); #1;
      cyc++;
   endtask

   task automatic drain();
      int g = 0;
      while ((rd_pend | wr_pend) != '0 && g < 60) begin step(0); g++; end
      vecs++; if ((rd_pend | wr_pend) != '0) begin errs++; $display("FAIL drain_timeout got pending %b/%b want 0", rd_pend, wr_pend); end
      repeat (RL+1) step(0);
   endtask

   task automatic test_reset();
      model_reset();
      fill = 1'b1; rd_req_valid = '1; wr_req_valid = '1;
      #1 reset_n = 1'b0;
      repeat (2) @(posedge clock);
      fill = 1'b0;
      @(negedge clock);
      vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL reset_busy got %b want 1", busy); end
      vecs++; if (rd_req_ready !== '0 || wr_req_ready !== '0) begin errs++; $display("FAIL reset_ready got %b/%b want 0", rd_req_ready, wr_req_ready); end
      vecs++; if (rd_resp_valid !== '0) begin errs++; $display("FAIL reset_resp got %b want 0", rd_resp_valid); end
      @(posedge clock); #1;
      reset_n = 1'b1; cyc = 0;
   endtask

   task automatic test_clear();
      int nb = 0;
      for (int i = 0; i < 20; i++) begin step(0); if (obs_busy) nb++; end
      vecs++; if (nb != 16) begin errs++; $display("FAIL clear_len got %0d want 16", nb); end
      rd_pend[3] = 1'b1; rd_a[3] = 4'd7;
      drain();
   endtask

   task automatic test_rr_reads();
      int order[$];
      for (int i = 0; i < NR; i++) begin
         wr_pend[i] = 1'b1; wr_a[i] = AW'(i+1); wr_d[i] = DW'(16'h11 * (i+1));
      end
      drain();
      for (int i = 0; i < NR; i++) begin rd_pend[i] = 1'b1; rd_a[i] = AW'(i+1); end
      for (int g = 0; g < 6; g++) begin
         step(0);
         if (obs_rg != '0) order.push_back($clog2(obs_rg));
      end
      vecs++; if (order.size() != 4) begin errs++; $display("FAIL rr_count got %0d want 4", order.size()); end
      for (int i = 0; i < order.size() && i < 4; i++) begin
         vecs++; if (order[i] != i) begin errs++; $display("FAIL rr_order slot %0d got %0d want %0d", i, order[i], i); end
      end
      drain();
   endtask

   task automatic test_same_addr();
      wr_pend[2] = 1'b1; wr_a[2] = 4'd5; wr_d[2] = 16'hBEEF;
      rd_pend[1] = 1'b1; rd_a[1] = 4'd5;
      step(0);
      vecs++; if (obs_rg !== 4'b0010 || obs_wg !== 4'b0100) begin errs++; $display("FAIL same_cycle_grant got %b/%b want 0010/0100", obs_rg, obs_wg); end
      rd_pend[1] = 1'b1;
      drain();
   endtask

   task automatic test_fairness();
      int n0 = 0, n3 = 0;
      logic [DW-1:0] seq = 16'h0;
      for (int j = 0; j < 8; j++) begin
         if (!wr_pend[0]) begin wr_pend[0] = 1'b1; wr_a[0] = 4'd8; wr_d[0] = 16'hA000 | seq; seq++; end
         if (!wr_pend[3]) begin wr_pend[3] = 1'b1; wr_a[3] = 4'd9; wr_d[3] = 16'hB000 | seq; seq++; end
         step(0);
         if (obs_wg[0]) n0++;
         if (obs_wg[3]) n3++;
      end
      vecs++; if (n0 != 4 || n3 != 4) begin errs++; $display("FAIL fairness got %0d/%0d want 4/4", n0, n3); end
      drain();
      rd_pend[1] = 1'b1; rd_a[1] = 4'd8; rd_pend[2] = 1'b1; rd_a[2] = 4'd9;
      drain();
   endtask

   task automatic test_clear_during_read();
      int nb = 0;
      rd_pend[0] = 1'b1; rd_a[0] = 4'd4;
      step(1);
      rd_pend[2] = 1'b1; rd_a[2] = 4'd4;
      for (int i = 0; i < 18; i++) begin step(0); if (obs_busy) nb++; end
      vecs++; if (nb != 16) begin errs++; $display("FAIL reclear_len got %0d want 16", nb); end
      drain();
   endtask

   task automatic test_async_reset();
      rd_pend[1] = 1'b1; rd_a[1] = 4'd3;
      step(0);
      #2 reset_n = 1'b0;
      model_reset();
      m_mem[0] = '0;
      repeat (3) begin
         @(negedge clock);
         vecs++; if (rd_resp_valid !== '0 || busy !== 1'b1) begin errs++; $display("FAIL async_reset got resp=%b busy=%b want 0000/1", rd_resp_valid, busy); end
      end
      @(posedge clock); #1;
      reset_n = 1'b1;
      for (int i = 0; i < 17; i++) step(0);
      rd_pend[0] = 1'b1; rd_a[0] = 4'd3;
      drain();
   endtask

   task automatic test_random();
      for (int j = 0; j < 400; j++) begin
         for (int i = 0; i < NR; i++) begin
            if (!rd_pend[i] && $urandom_range(2) == 0) begin rd_pend[i] = 1'b1; rd_a[i] = AW'($urandom_range(DEPTH-1)); end
            if (!wr_pend[i] && $urandom_range(2) == 0) begin wr_pend[i] = 1'b1; wr_a[i] = AW'($urandom_range(DEPTH-1)); wr_d[i] = DW'($urandom); end
         end
         step($urandom_range(63) == 0);
      end
      drain();
   endtask

   initial begin
      for (int i = 0; i < NR; i++) begin rd_a[i] = '0; wr_a[i] = '0; wr_d[i] = '0; end
      test_reset();
      test_clear();
      test_rr_reads();
      test_same_addr();
      test_fairness();
      test_clear_during_read();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got no finish want finish");
      $fatal(1);
   end
endmodule

// File: doc/uram_port_arbiter.md
Name: uram_port_arbiter

Overview:
- Shares one simple-dual-port URAM bank between NUM_REQ requesters.
- Provides round-robin arbitration on the read port and on the write port independently.
- Routes each read response back to its requester after the fixed memory read latency.
- Owns a clear sequencer that zero-fills the whole bank after reset or on command. It sits between the cores' memory clients and the URAM wrapper.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 16, word width
ADDRESS_WIDTH, 14, word address width; bank depth = 2^ADDRESS_WIDTH
READ_LATENCY, 2, memory read latency in cycles (>=1); must equal the wrapper's value

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
rd_req_valid  in  NUM_REQ  per-requester read request
rd_req_ready  out  NUM_REQ  one-hot read grant
rd_req_addr  in  NUM_REQ*ADDRESS_WIDTH  packed read addresses, requester i at slice i
rd_resp_valid  out  NUM_REQ  one-hot read response strobe
rd_resp_data  out  DATA_WIDTH  read data, shared by all requesters
wr_req_valid  in  NUM_REQ  per-requester write request
wr_req_ready  out  NUM_REQ  one-hot write grant
wr_req_addr  in  NUM_REQ*ADDRESS_WIDTH  packed write addresses
wr_req_data  in  NUM_REQ*DATA_WIDTH  packed write data
clear_start  in  1  pulse that requests a full-bank zero fill
busy  out  1  high while clearing
mem_raddr  out  ADDRESS_WIDTH  to wrapper read address
mem_dout  in  DATA_WIDTH  from wrapper read data
mem_wen  out  1  to wrapper write enable
mem_waddr  out  ADDRESS_WIDTH  to wrapper write address
mem_din  out  DATA_WIDTH  to wrapper write data

Behaviour:
- Reset (reset_n=0, asynchronous) puts the block in the following state:
  - FSM=CLEAR, clear counter=0.
  - Both round-robin pointers=0, so requester 0 has highest priority.
  - Response tag pipeline emptied.
  - rd_resp_valid=0, all readies=0, busy=1.
  - mem_wen=1, mem_waddr=0, mem_din=0 once reset deasserts.
- FSM has two states, CLEAR and RUN.
- CLEAR state:
  - Each cycle: mem_wen=1, mem_waddr=counter, mem_din=0, counter+1.
  - When counter reaches 2^ADDRESS_WIDTH-1, write that address and go to RUN next cycle. Clear therefore takes exactly 2^ADDRESS_WIDTH cycles.
  - All rd_req_ready and wr_req_ready are 0. busy=1. clear_start is ignored.
- RUN state:
  - busy=0.
  - clear_start=1 moves the FSM to CLEAR next cycle with counter=0. Reads and writes granted in that same cycle still proceed.
- Read arbitration (RUN only, combinational grant):
  - Search starts at rd_ptr and wraps; the first valid requester gets rd_req_ready.
  - A read handshake in cycle t means valid&ready.
  - mem_raddr = the granted address in cycle t. When there is no grant, mem_raddr holds its last value (don't-care).
  - On handshake, rd_ptr = granted index + 1 (mod NUM_REQ).
- Read response:
  - A one-hot tag shifts through a READ_LATENCY-deep registered pipeline.
  - rd_resp_valid = tag at stage READ_LATENCY-1. It asserts in cycle t+READ_LATENCY, rd_resp_data = mem_dout.
  - There is no response backpressure; requesters must sink the data.
  - Back-to-back grants give one response per cycle.
  - In-flight responses complete normally even if CLEAR begins.
- Write arbitration works the same way, with an independent wr_ptr:
  - mem_wen = 1 on handshake.
  - mem_waddr and mem_din = the granted slices.
  - mem_wen=0 when no grant in RUN.
- A single requester may be granted a read and a write in the same cycle.
- Ordering:
  - A read granted in the same cycle as a write to the same address returns the old data.
  - A read granted one or more cycles later returns the new data.
- Requirement on requesters: valid must stay high, with address and data stable, until ready.
- No arithmetic beyond wrap-around pointer and counter increments. The counter is ADDRESS_WIDTH+1 bits wide or detects terminal count.

Test Plan:
- ADDRESS_WIDTH=4, prefill memory with 0xFFFF, release reset -> busy=1 for exactly 16 cycles, mem_wen=1 with waddr 0..15 and din=0; all readies 0; then busy=0; reading addr 7 returns 0x0000.
- In RUN, all 4 requesters hold rd_req_valid with addrs 1,2,3,4 (data 0x11,0x22,0x33,0x44) -> grants 0,1,2,3 on consecutive cycles; rd_resp_valid one-hot 0001,0010,0100,1000 on cycles t+2..t+5 with data 0x11..0x44.
- Requester 2 writes 0xBEEF to addr 5 in cycle t while requester 1 reads addr 5 in cycle t -> old value returned; repeat the read at t+1 -> 0xBEEF at t+3.
- Requesters 0 and 3 each issue continuous writes -> grants alternate 0,3,0,3; neither starves; memory holds last data of each.
- Issue a read in cycle t with clear_start=1 in cycle t -> response still delivered at t+2 with the pre-clear data; busy rises at t+1; readies stay 0 for 16 cycles.
- Assert reset_n=0 asynchronously one cycle after a read grant -> rd_resp_valid stays 0 (no stale response); FSM restarts CLEAR from address 0.
